bsh_arb: RTL
============

# bsh_arb

Round-robin arbiter and sequencer that shares one `bsh_32` barrel shifter among `NREQ` requesters. Each requester issues shift operations (data, direction, amount) over a valid/ready handshake. The block grants one request per cycle, drives the shared shifter, and registers the result with the granted requester's ID on a single response channel. It sits between the shift-using clients and the combinational `bsh_32` datapath.

## Interface

**Parameters**
- `NREQ`, default 4, number of requesters (2..8).
- `IDW`, default `$clog2(NREQ)`, width of the requester ID.

**Ports**
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input `NREQ`: per-requester request valid.
- `req_ready` output `NREQ`: per-requester accept. At most one bit is set per cycle.
- `req_data` input `NREQ*32`: operand for requester *i*, in bits `[32i+31:32i]`.
- `req_dir` input `NREQ`: shift direction per requester; 0 = left, 1 = right.
- `req_sh` input `NREQ*5`: shift amount 0..31 per requester.
- `rsp_valid` output 1: response register holds a result.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_data` output 32: shifted result.
- `rsp_id` output `IDW`: index of the requester that produced `rsp_data`.

## Operation

- **Shift semantics:** logical shift with zero fill, as `bsh_32` implements. `sh = 0` passes data through unchanged.
- **Can-accept condition:** `accept_ok = !rsp_valid || rsp_ready`, i.e. the response register is empty or draining this cycle.
- **Arbitration:** round-robin pointer `ptr` (`IDW` bits).
  - The winner is the first asserted `req_valid[i]` searching from index `ptr` upward, wrapping modulo `NREQ`.
  - Winner is combinational from current `req_valid` and `ptr`.
  - `req_ready[win] = accept_ok && any(req_valid)`. All other `req_ready` bits are 0.
- **Transfer:** occurs when `req_valid[i] && req_ready[i]`.
  - The winner's `data`/`dir`/`sh` drive the `bsh_32` inputs.
  - Result and `win` load into `rsp_data`/`rsp_id`; `rsp_valid` sets to 1.
  - `ptr` loads `(win + 1) mod NREQ`.
- **Pointer hold:** with no transfer, `ptr` holds. A requester that was granted but not transferred cannot exist, because ready implies transfer when valid.
- **Response drain:** `rsp_valid && rsp_ready` with no new transfer clears `rsp_valid`. With a simultaneous transfer, `rsp_valid` stays 1 and the register reloads, giving full throughput of 1 op/cycle.
- **Backpressure:** `rsp_valid && !rsp_ready` drives all `req_ready` to 0 and holds `rsp_data`/`rsp_id` stable.
- **Requester rules:**
  - A requester must hold valid and payload stable until accepted.
  - The block ignores payload changes while valid is low.
- **State:** `ptr`, `rsp_valid`, `rsp_data`, `rsp_id`. There is no further FSM. The two-state view is EMPTY (`rsp_valid = 0`) and FULL (`rsp_valid = 1`):
  - EMPTY → FULL on a transfer.
  - FULL → EMPTY on a drain with no transfer.
  - FULL → FULL on a drain with a transfer, or on a stall.

## Timing

- **Reset values:** `rsp_valid = 0`, `rsp_data = 0`, `rsp_id = 0`, `ptr = 0`. `req_ready` is 0 during reset (combinational from `rst`).
- **Latency:** request accepted in cycle N gives `rsp_valid` high in cycle N+1. The result is fixed in the register from cycle N+1.
- **Combinational paths:** `rsp_ready` → `req_ready` and `req_valid` → `req_ready`. There is no path from any input to `rsp_*`.
- **Reset mid-operation:** a pending response is discarded, with no completion. Requesters must re-issue after reset deasserts.
- **Simultaneous valids:** strictly one grant per cycle. Under continuous full load each requester is served once every `NREQ` cycles, and the worst-case wait is `NREQ-1` grants.
- **Non-power-of-two `NREQ`:** wrap uses explicit compare to `NREQ-1`, not bit truncation.

## Structure

- Package `bsh_pkg`:
  - `localparam BSH_W = 32`, `BSH_SHW = 5`.
  - `typedef struct packed { logic [31:0] data; logic dir; logic [4:0] sh; } bsh_op_t`.
  - Direction constants `BSH_LEFT = 1'b0`, `BSH_RIGHT = 1'b1`.
- Sub-modules:
  - `bsh_32` is instantiated unmodified as the shared datapath.
  - One natural helper is `rr_pick` (combinational: `valid` vector + `ptr` → one-hot grant + index), reusable by other arbiters.

## Test plan

- **Reset:** assert `rst` mid-transfer with `rsp_valid = 1` → `rsp_valid`, `rsp_data`, `rsp_id`, `ptr` all 0 immediately; all `req_ready = 0`.
- **Single left shift:** req0 only, `data = 0x18A00000`, `dir = 0`, `sh = 10`, `rsp_ready = 1` → next cycle `rsp_valid = 1`, `rsp_data = 0x80000000`, `rsp_id = 0`.
- **Single right shift:** req2 only, `data = 0x00FF0003`, `dir = 1`, `sh = 20` → `rsp_data = 0x0000000F`, `rsp_id = 2`; `sh = 0` case returns the operand unchanged.
- **Round-robin fairness:** all 4 valid continuously, `rsp_ready = 1` → `rsp_id` sequence 0,1,2,3,0,… with one response per cycle and no bubbles.
- **Backpressure:** hold `rsp_ready = 0` for 3 cycles with req1 and req3 valid → all `req_ready = 0`, `rsp_*` stable. On release, same-cycle drain+load occurs and `ptr` advances only on accepted grants.
- **Wrap/skip:** `ptr = 3`, only req1 valid → req1 granted, `ptr` becomes 2. Then req0 and req2 valid → req2 granted first.

Source files
------------

// File: rtl/bsh_pkg.sv
// Shared types and constants for the barrel-shifter arbiter slice.
package bsh_pkg;

    localparam int BSH_W   = 32;
    localparam int BSH_SHW = 5;

    localparam logic BSH_LEFT  = 1'b0;
    localparam logic BSH_RIGHT = 1'b1;

    typedef struct packed {
        logic [31:0] data;
        logic        dir;
        logic [4:0]  sh;
    } bsh_op_t;

endpackage

// File: rtl/bsh_32.sv
// Combinational 32-bit logical barrel shifter, zero fill; dir 0 = left, 1 = right.
module bsh_32
    import bsh_pkg::*;
(
    input  logic [BSH_W-1:0]   data,
    input  logic               dir,
    input  logic [BSH_SHW-1:0] sh,
    output logic [BSH_W-1:0]   result
);

    assign result = (dir == BSH_RIGHT) ? (data >> sh) : (data << sh);

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted valid at or above ptr, wrapping at N-1.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            logic [IW:0] cand;
            cand = {1'b0, ptr} + (IW+1)'(k);
            // explicit wrap so non-power-of-two N never aliases onto unused indices
            if (cand > (IW+1)'(N-1)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found && valid[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
        grant[idx] = found;
        any        = found;
    end

endmodule

// File: rtl/bsh_arb.sv
// Round-robin arbiter sharing one bsh_32 among NREQ requesters, one registered response channel.
module bsh_arb
    import bsh_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*BSH_W-1:0]   req_data,
    input  logic [NREQ-1:0]         req_dir,
    input  logic [NREQ*BSH_SHW-1:0] req_sh,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [BSH_W-1:0]        rsp_data,
    output logic [IDW-1:0]          rsp_id
);

    bsh_op_t         ops [NREQ];
    bsh_op_t         sel_op;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic            any_valid;
    logic            accept_ok;
    logic            xfer;
    logic [BSH_W-1:0] shift_res;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            ops[i].data = req_data[BSH_W*i +: BSH_W];
            ops[i].dir  = req_dir[i];
            ops[i].sh   = req_sh[BSH_SHW*i +: BSH_SHW];
        end
    end

    rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .any   (any_valid)
    );

    assign sel_op = ops[win];

    bsh_32 u_bsh (
        .data   (sel_op.data),
        .dir    (sel_op.dir),
        .sh     (sel_op.sh),
        .result (shift_res)
    );

    // ready depends on rsp_ready combinationally so a drain and reload share one cycle
    assign accept_ok = !rsp_valid || rsp_ready;
    assign xfer      = any_valid && accept_ok && !rst;
    assign req_ready = xfer ? grant : '0;
    assign ptr_next  = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (xfer) begin
            ptr       <= ptr_next;
            rsp_valid <= 1'b1;
            rsp_data  <= shift_res;
            rsp_id    <= win;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
